// File: rtl/ky32_enc.sv
// KY32 instruction encoder: symbolic micro-ops in, RV32I words out, LI expanded to LUI/ADDI.
// Define KY32_ENC_COUNT_EN to add the word_cnt output (count of words handed to the sink).
module ky32_enc #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_op,
    input  logic [4:0]      in_rd,
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rs2,
    input  logic [XLEN-1:0] in_imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_insn,
    output logic            out_last,
    output logic            err
`ifdef KY32_ENC_COUNT_EN
    ,
    output logic [31:0]     word_cnt
`endif
);

    typedef enum logic {IDLE, EMIT2} state_e;

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_LD  = 7'b0000011;
    localparam logic [6:0] OPC_ST  = 7'b0100011;
    localparam logic [6:0] OPC_BR  = 7'b1100011;
    localparam logic [6:0] OPC_LUI = 7'b0110111;
    localparam logic [6:0] OPC_JAL = 7'b1101111;

    state_e            state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   out_insn_q, out_insn_d;
    logic              out_last_q, out_last_d;
    logic              err_q, err_d;
    logic [XLEN-1:0]   pend_q, pend_d;

    logic [XLEN-1:0]   enc_word, enc_second;
    logic              enc_last, enc_bad, enc_two;
    logic [2:0]        f3;
    logic [6:0]        f7;
    logic              fit12, fit13, fit21;
    logic [19:0]       li_hi;
    logic              accept, out_fire;

    assign in_ready  = (state_q == IDLE) & (~out_valid_q | out_ready);
    assign accept    = in_valid & in_ready;
    assign out_fire  = out_valid_q & out_ready;
    assign out_valid = out_valid_q;
    assign out_insn  = out_insn_q;
    assign out_last  = out_last_q;
    assign err       = err_q;

    // Signed-range checks: all bits above the field must equal its sign bit.
    assign fit12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign fit13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
    assign fit21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);
    // Rounding the upper part compensates for the sign-extended low 12 bits of the ADDI.
    assign li_hi = in_imm[31:12] + {19'd0, in_imm[11]};

    always_comb begin
        f3 = 3'b000;
        f7 = 7'b0000000;
        case (in_op)
            5'd1:        f7 = 7'b0100000;
            5'd2, 5'd8:  f3 = 3'b111;
            5'd3, 5'd9:  f3 = 3'b110;
            5'd4, 5'd10: f3 = 3'b100;
            5'd5:        f3 = 3'b001;
            5'd6:        begin f3 = 3'b101; f7 = 7'b0100000; end
            5'd11, 5'd12: f3 = 3'b010;
            5'd14:       f3 = 3'b001;
            default:     ;
        endcase
    end

    always_comb begin
        enc_word   = '0;
        enc_second = '0;
        enc_last   = 1'b1;
        enc_bad    = 1'b0;
        enc_two    = 1'b0;
        case (in_op)
            5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6:
                enc_word = {f7, in_rs2, in_rs1, f3, in_rd, OPC_R};
            5'd7, 5'd8, 5'd9, 5'd10: begin
                enc_bad  = ~fit12;
                enc_word = {in_imm[11:0], in_rs1, f3, in_rd, OPC_I};
            end
            5'd11: begin
                enc_bad  = ~fit12;
                enc_word = {in_imm[11:0], in_rs1, f3, in_rd, OPC_LD};
            end
            5'd12: begin
                enc_bad  = ~fit12;
                enc_word = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], OPC_ST};
            end
            5'd13, 5'd14: begin
                enc_bad  = ~fit13 | in_imm[0];
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3,
                            in_imm[4:1], in_imm[11], OPC_BR};
            end
            5'd15:
                enc_word = {in_imm[31:12], in_rd, OPC_LUI};
            5'd16: begin
                enc_bad  = ~fit21 | in_imm[0];
                enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OPC_JAL};
            end
            5'd17: begin
                if (fit12) begin
                    enc_word = {in_imm[11:0], 5'd0, 3'b000, in_rd, OPC_I};
                end else begin
                    enc_word = {li_hi, in_rd, OPC_LUI};
                    if (in_imm[11:0] != 12'd0) begin
                        enc_two    = 1'b1;
                        enc_last   = 1'b0;
                        enc_second = {in_imm[11:0], in_rd, 3'b000, in_rd, OPC_I};
                    end
                end
            end
            default: enc_bad = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q & ~out_ready;
        out_insn_d  = out_insn_q;
        out_last_d  = out_last_q;
        err_d       = 1'b0;
        pend_d      = pend_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (enc_bad) begin
                        err_d = 1'b1;
                    end else begin
                        out_valid_d = 1'b1;
                        out_insn_d  = enc_word;
                        out_last_d  = enc_last;
                        if (enc_two) begin
                            state_d = EMIT2;
                            pend_d  = enc_second;
                        end
                    end
                end
            end
            EMIT2: begin
                // The LUI is still in the output register; swap in the ADDI as it leaves.
                if (out_fire) begin
                    out_valid_d = 1'b1;
                    out_insn_d  = pend_q;
                    out_last_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_insn_q  <= '0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
            pend_q      <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_insn_q  <= out_insn_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
            pend_q      <= pend_d;
        end
    end

`ifdef KY32_ENC_COUNT_EN
    logic [31:0] cnt_q, cnt_d;

    assign cnt_d    = out_fire ? cnt_q + 32'd1 : cnt_q;
    assign word_cnt = cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`endif

endmodule

// File: doc/ky32_enc.md
Name: ky32_enc

Overview:
- Sequential instruction encoder for the KY32 core: the inverse of the KY32 control/decode path.
- Accepts symbolic micro-ops (op id, rd, rs1, rs2, 32-bit imm) over a valid/ready handshake.
- Emits 32-bit RV32I-format instruction words over a second valid/ready handshake.
- Feeds the boot-ROM generator and the self-test stimulus path. Expands the LI pseudo-op into LUI/ADDI sequences.

Parameters:
- XLEN, 32, instruction/immediate width; only 32 is supported.

Ports:
- clk  in  1  core clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  micro-op present.
- in_ready  out  1  micro-op accepted when in_valid & in_ready.
- in_op  in  5  op id: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRA, 7 ADDI, 8 ANDI, 9 ORI, 10 XORI, 11 LW, 12 SW, 13 BEQ, 14 BNE, 15 LUI, 16 JAL, 17 LI; 18-31 illegal.
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_imm  in  32  immediate / byte offset / LI value.
- out_valid  out  1  instruction word valid.
- out_ready  in  1  sink accepts the word when out_valid & out_ready.
- out_insn  out  32  encoded instruction.
- out_last  out  1  word is the final word of its micro-op.
- err  out  1  one-cycle pulse: micro-op rejected.

Behaviour:
- Reset values: out_valid=0, out_insn=0, out_last=0, err=0, state=IDLE. in_ready=1 after reset.
- Reset mid-sequence discards any pending second word.
- Output register is one entry.
- in_ready = (state==IDLE) & (~out_valid | out_ready). This gives full throughput for single-word ops.
- Latency: a word appears on out_* the cycle after acceptance (registered).
- out_insn, out_last and out_valid hold stable while out_valid & ~out_ready.
- Opcode fields: R 0110011, I 0010011, LW 0000011/f3 010, SW 0100011/f3 010, BEQ 1100011/f3 000, BNE 1100011/f3 001, LUI 0110111, JAL 1101111.
- R-type funct3: ADD/SUB 000, SLL 001, XOR 100, SRA 101, OR 110, AND 111. funct7 is 0100000 for SUB/SRA, else 0.
- I-type funct3 matches the R-type counterpart.
- Range checks:
  - I/LW/SW immediates must be 12-bit signed.
  - BEQ/BNE offsets must be 13-bit signed and even.
  - JAL offsets must be 21-bit signed and even.
  - LUI uses in_imm[31:12]; in_imm[11:0] is ignored.
- Failed range check or illegal op: micro-op is consumed, err=1 for exactly one cycle, no word is emitted, and state stays IDLE.
- Unused register fields are encoded as their input values only where the format has them; other bits follow the format.
- LI state machine (states IDLE, EMIT2):
  - lo = sext(imm[11:0]); hi = (imm + 0x800) >> 12, mod 2^20.
  - If imm is within [-2048, 2047]: emit ADDI rd,x0,imm with out_last=1; stay IDLE.
  - Else if lo==0: emit LUI rd,hi with out_last=1.
  - Else: emit LUI rd,hi with out_last=0, go to EMIT2. When that word is accepted, load ADDI rd,rd,lo with out_last=1 and return to IDLE.
  - in_ready=0 throughout EMIT2.
- Simultaneous acceptance of the current output and loading of the next word in the same cycle is required; there are no bubbles.

Optional Feature:
- KY32_ENC_COUNT_EN.
- Defined: adds output word_cnt (32 bits, out).
  - Increments on every out_valid & out_ready; wraps at 2^32.
  - Cleared by rst.
  - Rejected micro-ops do not count.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- ADD rd=3, rs1=1, rs2=2 -> one word 0x002081B3, out_last=1, next cycle after accept.
- LI rd=5, imm=0x12345678 -> 0x123452B7 (out_last=0), then 0x67828293 (out_last=1); in_ready=0 between the two words.
- LI rd=1, imm=0xFFFFFFFF -> single 0xFFF00093. LI rd=6, imm=0x00001000 -> single 0x00001337.
- BEQ rs1=1, rs2=2, imm=8 -> 0x00208463. BEQ imm=7 -> err pulse, no out_valid.
- in_op=31 -> err high exactly one cycle, in_ready stays 1, out_valid stays 0.
- out_ready held low 5 cycles during the LI sequence -> out_insn stable at 0x123452B7, no input accepted; assert rst mid-hold -> all outputs 0 immediately, EMIT2 word never appears.
